pic_prog_loader: RTL

//  Boot/programming controller for the PIC10F20x cpu. Sits between a host byte stream and the cpu's

---
 rtl/pic_prog_loader_pkg.sv | 39 +++
 rtl/pic_prog_loader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pic_prog_loader_pkg.sv
// ---------------------------------------------------------------------------
// pic_prog_loader_pkg
//  Shared widths, state type and helpers for the PIC10F20x program loader.
//  The instruction width and memory depth mirror the cpu's own parameters so
//  the loader's write port lines up with the cpu's instruction memory.
// ---------------------------------------------------------------------------
package pic_prog_loader_pkg;

    localparam int PIC_INSTR_WIDTH        = 12;
    localparam int L2_PIC_INSTR_MEM_DEPTH = 9;

    // Cycles cpu_rst stays high after program_mode drops; must be >= 1.
    localparam int RST_HOLD = 4;

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    // Largest usable word count: exactly one full instruction memory.
    localparam logic [L2_PIC_INSTR_MEM_DEPTH:0] MAX_LEN =
        {1'b1, {L2_PIC_INSTR_MEM_DEPTH{1'b0}}};

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_RX_LO = 3'd1,
        ST_RX_HI = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHK   = 3'd4,
        ST_HOLD  = 3'd5,
        ST_RUN   = 3'd6,
        ST_ERR   = 3'd7
    } state_t;

    // Clamp a requested word count so the write address can never wrap.
    function automatic logic [L2_PIC_INSTR_MEM_DEPTH:0] sat_len(
        input logic [L2_PIC_INSTR_MEM_DEPTH:0] len
    );
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

endpackage

// File: rtl/pic_prog_loader.sv
// ---------------------------------------------------------------------------
// pic_prog_loader
//  Boot/programming controller for the PIC10F20x cpu. Holds the cpu in reset
//  and program mode, pulls instruction words (low byte, then high byte) from a
//  byte stream, writes them into instruction memory, then checks an 8-bit
//  modulo-256 checksum byte. On a match program_mode drops and cpu_rst is
//  released RST_HOLD cycles later; on a mismatch the loader parks in ERR.
//
// Ports
//  clk           clock, all logic on posedge
//  rst           asynchronous reset, active-low
//  load_start    1-cycle pulse, begin a load (honoured in WAIT, RUN, ERR)
//  load_len      word count sampled with load_start, saturated to 2**L2
//  s_valid/s_ready/s_data   byte stream, transfer on s_valid && s_ready
//  we/waddr/wdata           registered instruction-memory write port
//  program_mode  cpu program_mode input
//  cpu_rst       cpu reset input, 1 = cpu held in reset
//  busy          load in progress (RX_LO..HOLD)
//  done          1-cycle pulse on the first RUN cycle
//  error         checksum mismatch, sticky until the next accepted load_start
// ---------------------------------------------------------------------------
module pic_prog_loader
    import pic_prog_loader_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load_start,
    input  logic [L2_PIC_INSTR_MEM_DEPTH:0]   load_len,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [7:0]                        s_data,
    output logic                              we,
    output logic [L2_PIC_INSTR_MEM_DEPTH-1:0] waddr,
    output logic [PIC_INSTR_WIDTH-1:0]        wdata,
    output logic                              program_mode,
    output logic                              cpu_rst,
    output logic                              busy,
    output logic                              done,
    output logic                              error
);

    localparam int L2 = L2_PIC_INSTR_MEM_DEPTH;

    state_t            state;
    state_t            state_nxt;
    logic [L2:0]       len_q;
    logic [L2:0]       cnt_q;
    logic [L2-1:0]     addr_q;
    logic [7:0]        lo_q;
    logic [7:0]        sum_q;
    logic [HOLD_W-1:0] hold_q;
    logic              xfer;
    logic              start_ok;
    logic              last_word;
    logic              hold_last;

    assign xfer      = s_valid && s_ready;
    assign last_word = ((cnt_q + (L2+1)'(1)) == len_q);
    assign hold_last = (hold_q == HOLD_W'(RST_HOLD - 1));

    // State register. Reset lands in WAIT, which by itself forces the cpu
    // into reset and program mode through the decoded outputs below.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the state-decoded control outputs. The cpu only
    // leaves program mode once the checksum has matched, and only leaves
    // reset after the hold window has expired.
    always_comb begin
        state_nxt    = state;
        start_ok     = 1'b0;
        s_ready      = 1'b0;
        program_mode = 1'b1;
        cpu_rst      = 1'b1;
        busy         = 1'b0;

        case (state)
            ST_WAIT, ST_RUN, ST_ERR: begin
                if (load_start) begin
                    start_ok  = 1'b1;
                    state_nxt = (sat_len(load_len) == '0) ? ST_CHK : ST_RX_LO;
                end
            end
            ST_RX_LO: begin
                s_ready = 1'b1;
                if (xfer) state_nxt = ST_RX_HI;
            end
            ST_RX_HI: begin
                s_ready = 1'b1;
                if (xfer) state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                state_nxt = last_word ? ST_CHK : ST_RX_LO;
            end
            ST_CHK: begin
                s_ready = 1'b1;
                if (xfer) state_nxt = (s_data == sum_q) ? ST_HOLD : ST_ERR;
            end
            ST_HOLD: begin
                if (hold_last) state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_WAIT;
            end
        endcase

        if (state == ST_HOLD || state == ST_RUN) program_mode = 1'b0;
        if (state == ST_RUN)                     cpu_rst      = 1'b0;
        if (state == ST_RX_LO || state == ST_RX_HI || state == ST_WRITE ||
            state == ST_CHK   || state == ST_HOLD)
            busy = 1'b1;
    end

    // Datapath: word counters, running checksum, hold counter and the
    // registered write port. The write strobe is launched on the high-byte
    // handshake so that it is visible during exactly the WRITE cycle; the
    // upper nibble of the high byte is dropped from wdata but still summed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q  <= '0;
            cnt_q  <= '0;
            addr_q <= '0;
            lo_q   <= '0;
            sum_q  <= '0;
            hold_q <= '0;
            we     <= 1'b0;
            waddr  <= '0;
            wdata  <= '0;
            done   <= 1'b0;
            error  <= 1'b0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;

            if (start_ok) begin
                len_q  <= sat_len(load_len);
                cnt_q  <= '0;
                addr_q <= '0;
                sum_q  <= '0;
                hold_q <= '0;
                error  <= 1'b0;
            end

            if (state == ST_RX_LO && xfer) begin
                lo_q  <= s_data;
                sum_q <= sum_q + s_data;
            end

            if (state == ST_RX_HI && xfer) begin
                sum_q <= sum_q + s_data;
                we    <= 1'b1;
                waddr <= addr_q;
                wdata <= {s_data[3:0], lo_q};
            end

            if (state == ST_WRITE) begin
                addr_q <= addr_q + L2'(1);
                cnt_q  <= cnt_q + (L2+1)'(1);
            end

            if (state == ST_HOLD) begin
                if (hold_last) begin
                    hold_q <= '0;
                    done   <= 1'b1;
                end else begin
                    hold_q <= hold_q + HOLD_W'(1);
                end
            end

            if (state == ST_CHK && xfer && s_data != sum_q) begin
                error <= 1'b1;
            end
        end
    end

endmodule
